// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad digit-entry path.
package keypad_pkg;

    localparam int BCD_W = 4;
    localparam int KEY_N = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // OR of set-bit indices; only meaningful when exactly one bit is set.
    function automatic logic [BCD_W-1:0] onehot10_to_bcd(input logic [KEY_N-1:0] oh);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY_N; i++) begin
            if (oh[i]) r |= BCD_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_onehot_enc.sv
// Combinational decode of the 10-key pulse vector into a BCD digit plus validity flags.
module keypad_onehot_enc
    import keypad_pkg::*;
(
    input  logic [KEY_N-1:0] key_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             one_o,
    output logic             multi_o
);

    int unsigned pop;

    always_comb begin
        pop     = $countones(key_i);
        bcd_o   = onehot10_to_bcd(key_i);
        one_o   = (pop == 1);
        multi_o = (pop > 1);
    end

endmodule

// File: rtl/keypad_digit_entry.sv
// Assembles keypad pulses into a NUM_DIGITS-digit BCD entry with timeout abort and clear.
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [KEY_N-1:0]                keypad,
    input  logic                            clear,
    output logic [BCD_W*NUM_DIGITS-1:0]     digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_cnt,
    output logic                            value_valid,
    output logic                            busy,
    output logic                            key_err,
    output logic                            timeout
);

    localparam int DW    = BCD_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int CTR_W = $clog2(TIMEOUT_CYCLES);

    logic [BCD_W-1:0] bcd;
    logic             key_one;
    logic             key_multi;

    keypad_onehot_enc u_enc (
        .key_i   (keypad),
        .bcd_o   (bcd),
        .one_o   (key_one),
        .multi_o (key_multi)
    );

    state_t           state_q;
    logic [DW-1:0]    digits_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CTR_W-1:0] idle_q;
    logic             vv_q, kerr_q, tout_q;

    logic [DW-1:0]    digits_shift_d;
    logic [DW-1:0]    digits_first_d;
    logic [CNT_W-1:0] cnt_inc_d;

    // Shift form avoids an empty slice when NUM_DIGITS == 1.
    assign digits_shift_d = (digits_q << BCD_W) | DW'(bcd);
    assign digits_first_d = DW'(bcd);
    assign cnt_inc_d      = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            vv_q     <= 1'b0;
            kerr_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            vv_q   <= 1'b0;
            kerr_q <= 1'b0;
            tout_q <= 1'b0;
            if (clear) begin
                state_q  <= ST_IDLE;
                digits_q <= '0;
                cnt_q    <= '0;
                idle_q   <= '0;
            end else begin
                kerr_q <= key_multi;
                case (state_q)
                    ST_ENTRY: begin
                        if (key_one) begin
                            digits_q <= digits_shift_d;
                            cnt_q    <= cnt_inc_d;
                            idle_q   <= '0;
                            if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
                                state_q <= ST_DONE;
                                vv_q    <= 1'b1;
                            end
                        end else if (idle_q == CTR_W'(TIMEOUT_CYCLES - 1)) begin
                            // Abort takes precedence over a coincident multi-key error.
                            state_q  <= ST_IDLE;
                            digits_q <= '0;
                            cnt_q    <= '0;
                            idle_q   <= '0;
                            tout_q   <= 1'b1;
                            kerr_q   <= 1'b0;
                        end else begin
                            idle_q <= idle_q + CTR_W'(1);
                        end
                    end
                    default: begin
                        if (key_one) begin
                            digits_q <= digits_first_d;
                            cnt_q    <= CNT_W'(1);
                            idle_q   <= '0;
                            if (NUM_DIGITS == 1) begin
                                state_q <= ST_DONE;
                                vv_q    <= 1'b1;
                            end else begin
                                state_q <= ST_ENTRY;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign digits      = digits_q;
    assign digit_cnt   = cnt_q;
    assign value_valid = vv_q;
    assign busy        = (state_q == ST_ENTRY);
    assign key_err     = kerr_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed self-checking bench for keypad_digit_entry (NUM_DIGITS=4, TIMEOUT_CYCLES=16).
module tb_keypad_digit_entry;

    localparam int ND = 4;
    localparam int TC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  keypad;
    logic        clear;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic        value_valid, busy, key_err, timeout;

    int n_chk  = 0;
    int n_fail = 0;

    keypad_digit_entry #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(TC)) dut (
        .clk         (clk),
        .rst         (rst),
        .keypad      (keypad),
        .clear       (clear),
        .digits      (digits),
        .digit_cnt   (digit_cnt),
        .value_valid (value_valid),
        .busy        (busy),
        .key_err     (key_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns #1 after the edge.
    task automatic step(input logic [9:0] kp, input logic clr);
        @(negedge clk);
        keypad = kp;
        clear  = clr;
        @(posedge clk);
        #1;
        keypad = '0;
        clear  = 1'b0;
    endtask

    task automatic press(input int k);
        logic [9:0] kp;
        kp    = '0;
        kp[k] = 1'b1;
        step(kp, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 1'b0);
    endtask

    initial begin
        rst    = 1'b0;
        keypad = '0;
        clear  = 1'b0;
        #12;
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);
        chk("rst_pulses", 32'({value_valid, busy, key_err, timeout}), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Full entry 1,2,3,0
        press(1);
        chk("t1_first_digits", 32'(digits), 32'h0001);
        chk("t1_first_busy", 32'(busy), 32'd1);
        idle(3); press(2); idle(3); press(3);
        chk("t1_vv_early", 32'(value_valid), 32'd0);
        chk("t1_cnt3", 32'(digit_cnt), 32'd3);
        idle(3); press(0);
        chk("t1_digits", 32'(digits), 32'h1230);
        chk("t1_cnt", 32'(digit_cnt), 32'd4);
        chk("t1_vv", 32'(value_valid), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        idle(1);
        chk("t1_vv_once", 32'(value_valid), 32'd0);
        chk("t1_hold", 32'(digits), 32'h1230);

        // New key from DONE
        press(6);
        chk("t5_digits", 32'(digits), 32'h0006);
        chk("t5_cnt", 32'(digit_cnt), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_vv", 32'(value_valid), 32'd0);

        // Multi-key mid-entry
        step(10'h090, 1'b0);
        chk("t2_kerr", 32'(key_err), 32'd1);
        chk("t2_digits", 32'(digits), 32'h0006);
        chk("t2_cnt", 32'(digit_cnt), 32'd1);
        idle(1);
        chk("t2_kerr_once", 32'(key_err), 32'd0);

        step('0, 1'b1);
        chk("clr_digits", 32'(digits), 32'h0);
        chk("clr_busy", 32'(busy), 32'd0);

        // Timeout after 16 idle cycles
        press(5); press(9);
        idle(15);
        chk("t3_no_tout_yet", 32'(timeout), 32'd0);
        chk("t3_busy_pre", 32'(busy), 32'd1);
        idle(1);
        chk("t3_tout", 32'(timeout), 32'd1);
        chk("t3_digits", 32'(digits), 32'h0);
        chk("t3_cnt", 32'(digit_cnt), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        idle(1);
        chk("t3_tout_once", 32'(timeout), 32'd0);

        // Key on the 16th idle cycle beats timeout
        press(5); press(9);
        idle(15);
        press(4);
        chk("t3b_tout", 32'(timeout), 32'd0);
        chk("t3b_cnt", 32'(digit_cnt), 32'd3);
        chk("t3b_digits", 32'(digits), 32'h0594);
        idle(1);
        chk("t3b_busy", 32'(busy), 32'd1);

        // Clear together with a key
        step('0, 1'b1);
        press(8); press(8);
        step(10'h008, 1'b1);
        chk("t4_digits", 32'(digits), 32'h0);
        chk("t4_cnt", 32'(digit_cnt), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        // Clear together with the completing key
        press(1); press(2); press(3);
        step(10'h010, 1'b1);
        chk("t4_vv", 32'(value_valid), 32'd0);
        chk("t4_cnt2", 32'(digit_cnt), 32'd0);

        // Asynchronous reset mid-entry
        press(1); press(2);
        chk("t6_cnt_pre", 32'(digit_cnt), 32'd2);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_digits", 32'(digits), 32'h0);
        chk("t6_async_cnt", 32'(digit_cnt), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        press(7);
        chk("t6_digits", 32'(digits), 32'h0007);
        chk("t6_cnt", 32'(digit_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
